// File: rtl/sb_mem_bank_cfg_ctrl.sv
// Programming-side sequencer for a switch block memory-bank configuration array.
// Accepts a serial bitstream over valid/ready and writes one bank address per
// bit by driving bl[idx] with the data and pulsing wl[idx] through setup,
// pulse and hold phases so the word line never moves while its bit line does.
module sb_mem_bank_cfg_ctrl #(
  parameter int NUM_BITS = 36,
  parameter int WL_PULSE = 2,
  parameter int CW       = $clog2(NUM_BITS + 1)
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                start,
  input  logic                bit_valid,
  input  logic                bit_data,
  output logic                bit_ready,
  output logic [0:NUM_BITS-1] bl,
  output logic [0:NUM_BITS-1] wl,
  output logic                busy,
  output logic                done,
  output logic [CW-1:0]       bit_count
);

  localparam int            PW         = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(WL_PULSE - 1);
  localparam logic [CW-1:0] IDX_LAST   = CW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    WRITE,
    HOLD,
    DONE
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [CW-1:0]       idx;
  logic [CW-1:0]       idx_n;
  logic [CW-1:0]       count_n;
  logic [PW-1:0]       pulse;
  logic [PW-1:0]       pulse_n;
  logic                d;
  logic                d_n;
  logic [0:NUM_BITS-1] bl_n;
  logic [0:NUM_BITS-1] wl_n;

  // Next-state sequencing: one bit walks LOAD -> SETUP -> WRITE x WL_PULSE -> HOLD
  always_comb begin
    state_n = state;
    idx_n   = idx;
    count_n = bit_count;
    pulse_n = pulse;
    d_n     = d;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = LOAD;
          idx_n   = '0;
          count_n = '0;
        end
      end
      LOAD: begin
        if (bit_valid && bit_ready) begin
          d_n     = bit_data;
          state_n = SETUP;
        end
      end
      SETUP: begin
        pulse_n = '0;
        state_n = WRITE;
      end
      WRITE: begin
        if (pulse == PULSE_LAST) begin
          state_n = HOLD;
        end else begin
          pulse_n = pulse + 1'b1;
        end
      end
      HOLD: begin
        count_n = bit_count + 1'b1;
        if (idx == IDX_LAST) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = LOAD;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Bank line decode for the upcoming cycle so bl/wl can be registered
  always_comb begin
    bl_n = '0;
    wl_n = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (idx_n == CW'(i)) begin
        if (state_n inside {SETUP, WRITE, HOLD}) begin
          bl_n[i] = d_n;
        end
        if (state_n == WRITE) begin
          wl_n[i] = 1'b1;
        end
      end
    end
  end

  // State and registered outputs; reset drops every word line on the next edge
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state     <= IDLE;
      idx       <= '0;
      bit_count <= '0;
      pulse     <= '0;
      d         <= 1'b0;
      bl        <= '0;
      wl        <= '0;
      bit_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      bit_count <= count_n;
      pulse     <= pulse_n;
      d         <= d_n;
      bl        <= bl_n;
      wl        <= wl_n;
      bit_ready <= (state_n == LOAD);
      busy      <= (state_n inside {LOAD, SETUP, WRITE, HOLD});
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_sb_mem_bank_cfg_ctrl.sv
// Self-checking bench for sb_mem_bank_cfg_ctrl: default 36-bit bank plus a
// 4-bit / 1-cycle-pulse instance. Accepted bits go into a scoreboard queue
// and are popped when the matching word line rises.
module tb_sb_mem_bank_cfg_ctrl;

  localparam int NB  = 36;
  localparam int WLP = 2;
  localparam int SNB = 4;
  localparam int SWP = 1;

  typedef struct {
    int   idx;
    logic d;
  } sb_entry_t;

  logic          prog_clk;
  logic          pReset;
  logic          start;
  logic          bit_valid;
  logic          bit_data;
  logic          bit_ready;
  logic [0:NB-1] bl;
  logic [0:NB-1] wl;
  logic          busy;
  logic          done;
  logic [5:0]    bit_count;

  logic           s_start;
  logic           s_valid;
  logic           s_data;
  logic           s_ready;
  logic [0:SNB-1] s_bl;
  logic [0:SNB-1] s_wl;
  logic           s_busy;
  logic           s_done;
  logic [2:0]     s_count;

  int num_checks = 0;
  int num_fails  = 0;
  int cycle      = 0;
  int exp_idx    = 0;
  int elapsed;

  sb_entry_t sb_q[$];
  sb_entry_t s_q[$];

  sb_mem_bank_cfg_ctrl #(
    .NUM_BITS(NB),
    .WL_PULSE(WLP)
  ) u_dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .start    (start),
    .bit_valid(bit_valid),
    .bit_data (bit_data),
    .bit_ready(bit_ready),
    .bl       (bl),
    .wl       (wl),
    .busy     (busy),
    .done     (done),
    .bit_count(bit_count)
  );

  sb_mem_bank_cfg_ctrl #(
    .NUM_BITS(SNB),
    .WL_PULSE(SWP)
  ) u_small (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .start    (s_start),
    .bit_valid(s_valid),
    .bit_data (s_data),
    .bit_ready(s_ready),
    .bl       (s_bl),
    .wl       (s_wl),
    .busy     (s_busy),
    .done     (s_done),
    .bit_count(s_count)
  );

  // Free-running programming clock and an edge counter for latency checks
  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) cycle <= cycle + 1;

  // Hard stop in case some wait is never satisfied
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int wl_index(input logic [0:NB-1] v);
    for (int i = 0; i < NB; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int s_wl_index(input logic [0:SNB-1] v);
    for (int i = 0; i < SNB; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Monitor for the default instance: one-hot wl, scoreboard pop on wl rise,
  // bl stable around the pulse and pulse width of WLP cycles
  logic [0:NB-1] prev_wl = '0;
  logic [0:NB-1] prev_bl = '0;
  int            hi_cnt  = 0;
  always @(negedge prog_clk) begin
    sb_entry_t     e;
    logic [0:NB-1] eb;
    checkOutput("wl_onehot", 64'($onehot0(wl)), 64'(1));
    if (pReset) begin
      prev_wl = '0;
      prev_bl = '0;
      hi_cnt  = 0;
    end else begin
      if (wl != '0 && prev_wl == '0) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_pending", 64'(sb_q.size()), 64'(1));
        end else begin
          e  = sb_q.pop_front();
          eb = '0;
          eb[e.idx] = e.d;
          checkOutput("wl_index", 64'(wl_index(wl)), 64'(e.idx));
          checkOutput("bl_at_wl", 64'(bl), 64'(eb));
          checkOutput("bl_setup_stable", 64'(prev_bl), 64'(bl));
        end
        hi_cnt = 1;
      end else if (wl != '0) begin
        checkOutput("wl_steady", 64'(wl), 64'(prev_wl));
        hi_cnt++;
      end else if (prev_wl != '0) begin
        checkOutput("wl_width", 64'(hi_cnt), 64'(WLP));
        checkOutput("bl_hold_stable", 64'(bl), 64'(prev_bl));
      end
      prev_wl = wl;
      prev_bl = bl;
    end
  end

  // Same monitor for the small instance
  logic [0:SNB-1] s_prev_wl = '0;
  logic [0:SNB-1] s_prev_bl = '0;
  int             s_hi_cnt  = 0;
  always @(negedge prog_clk) begin
    sb_entry_t      e;
    logic [0:SNB-1] eb;
    checkOutput("s_wl_onehot", 64'($onehot0(s_wl)), 64'(1));
    if (pReset) begin
      s_prev_wl = '0;
      s_prev_bl = '0;
      s_hi_cnt  = 0;
    end else begin
      if (s_wl != '0 && s_prev_wl == '0) begin
        if (s_q.size() == 0) begin
          checkOutput("s_sb_pending", 64'(s_q.size()), 64'(1));
        end else begin
          e  = s_q.pop_front();
          eb = '0;
          eb[e.idx] = e.d;
          checkOutput("s_wl_index", 64'(s_wl_index(s_wl)), 64'(e.idx));
          checkOutput("s_bl_at_wl", 64'(s_bl), 64'(eb));
          checkOutput("s_bl_setup_stable", 64'(s_prev_bl), 64'(s_bl));
        end
        s_hi_cnt = 1;
      end else if (s_wl != '0) begin
        s_hi_cnt++;
      end else if (s_prev_wl != '0) begin
        checkOutput("s_wl_width", 64'(s_hi_cnt), 64'(SWP));
        checkOutput("s_bl_hold_stable", 64'(s_bl), 64'(s_prev_bl));
      end
      s_prev_wl = s_wl;
      s_prev_bl = s_bl;
    end
  end

  // Offer one bit to the default instance, optionally holding bit_valid low
  // for stall_len LOAD cycles first; returns #1 after the accepting edge
  task automatic send_bit(input logic d, input int stall_len);
    int guard;
    if (stall_len > 0) begin
      bit_valid = 1'b0;
      guard = 0;
      while (!bit_ready && guard < 20) begin
        @(negedge prog_clk);
        guard++;
      end
      repeat (stall_len) begin
        checkOutput("stall_ready", 64'(bit_ready), 64'(1));
        checkOutput("stall_wl_quiet", 64'(wl), 64'(0));
        @(posedge prog_clk);
        #1;
      end
    end
    bit_valid = 1'b1;
    bit_data  = d;
    guard = 0;
    while (!bit_ready && guard < 20) begin
      @(negedge prog_clk);
      guard++;
    end
    checkOutput("bit_ready", 64'(bit_ready), 64'(1));
    checkOutput("bit_count_at_load", 64'(bit_count), 64'(exp_idx));
    sb_q.push_back('{idx: exp_idx, d: d});
    exp_idx++;
    @(posedge prog_clk);
    #1;
  endtask

  // Start a load on the default instance and stream n_send bits; for a full
  // bank it waits for done and reports cycles from first bit_ready to done
  task automatic applyStimulus(input int n_send, input int stall_bit, input int start_bit,
                               input bit rand_data, output int elapsed_out);
    int   t0;
    int   guard;
    logic d;
    elapsed_out = 0;
    start = 1'b1;
    @(posedge prog_clk);
    #1;
    start   = 1'b0;
    exp_idx = 0;
    checkOutput("start_ready", 64'(bit_ready), 64'(1));
    checkOutput("start_busy", 64'(busy), 64'(1));
    checkOutput("start_done_clr", 64'(done), 64'(0));
    checkOutput("start_count_clr", 64'(bit_count), 64'(0));
    t0 = cycle;
    for (int i = 0; i < n_send; i++) begin
      d = rand_data ? 1'($urandom_range(0, 1)) : 1'(i % 2 == 0);
      send_bit(d, (i == stall_bit) ? 7 : 0);
      if (i == start_bit) begin
        @(posedge prog_clk);
        #1;
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        checkOutput("ignored_start_busy", 64'(busy), 64'(1));
        checkOutput("ignored_start_wl", 64'(wl_index(wl)), 64'(i));
      end
    end
    bit_valid = 1'b0;
    if (n_send == NB) begin
      guard = 0;
      while (!done && guard < 60) begin
        @(negedge prog_clk);
        guard++;
      end
      elapsed_out = cycle - t0;
      checkOutput("done_set", 64'(done), 64'(1));
      checkOutput("done_busy_low", 64'(busy), 64'(0));
      checkOutput("done_count", 64'(bit_count), 64'(NB));
      checkOutput("done_bl_zero", 64'(bl), 64'(0));
      checkOutput("done_wl_zero", 64'(wl), 64'(0));
      checkOutput("done_ready_low", 64'(bit_ready), 64'(0));
    end
  endtask

  // Full load of the 4-bit, single-cycle-pulse instance
  task automatic run_small(output int elapsed_out);
    int         t0;
    int         guard;
    logic [3:0] pat;
    pat = 4'b1011;
    s_start = 1'b1;
    @(posedge prog_clk);
    #1;
    s_start = 1'b0;
    checkOutput("s_start_ready", 64'(s_ready), 64'(1));
    t0 = cycle;
    for (int i = 0; i < SNB; i++) begin
      s_valid = 1'b1;
      s_data  = pat[i];
      guard = 0;
      while (!s_ready && guard < 20) begin
        @(negedge prog_clk);
        guard++;
      end
      checkOutput("s_bit_ready", 64'(s_ready), 64'(1));
      s_q.push_back('{idx: i, d: pat[i]});
      @(posedge prog_clk);
      #1;
    end
    s_valid = 1'b0;
    guard = 0;
    while (!s_done && guard < 40) begin
      @(negedge prog_clk);
      guard++;
    end
    elapsed_out = cycle - t0;
    checkOutput("s_done_set", 64'(s_done), 64'(1));
    checkOutput("s_done_busy_low", 64'(s_busy), 64'(0));
    checkOutput("s_done_count", 64'(s_count), 64'(SNB));
  endtask

  // Test sequence
  initial begin
    logic [0:NB-1] ew;
    pReset    = 1'b1;
    start     = 1'b0;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    s_start   = 1'b0;
    s_valid   = 1'b0;
    s_data    = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1;
    pReset = 1'b0;
    checkOutput("rst_wl", 64'(wl), 64'(0));
    checkOutput("rst_bl", 64'(bl), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_count", 64'(bit_count), 64'(0));
    checkOutput("rst_ready", 64'(bit_ready), 64'(0));
    checkOutput("rst_s_busy", 64'(s_busy), 64'(0));
    repeat (2) @(posedge prog_clk);
    #1;

    $display("[TB] reset in the middle of writing bit 5");
    applyStimulus(6, -1, -1, 1'b0, elapsed);
    @(posedge prog_clk);
    #1;
    ew = '0;
    ew[5] = 1'b1;
    checkOutput("pre_reset_wl5", 64'(wl), 64'(ew));
    pReset = 1'b1;
    @(posedge prog_clk);
    #1;
    checkOutput("reset_wl_drop", 64'(wl), 64'(0));
    @(posedge prog_clk);
    #1;
    pReset = 1'b0;
    sb_q.delete();
    checkOutput("mid_rst_wl", 64'(wl), 64'(0));
    checkOutput("mid_rst_bl", 64'(bl), 64'(0));
    checkOutput("mid_rst_busy", 64'(busy), 64'(0));
    checkOutput("mid_rst_done", 64'(done), 64'(0));
    checkOutput("mid_rst_count", 64'(bit_count), 64'(0));
    @(posedge prog_clk);
    #1;

    $display("[TB] full load, alternating data");
    applyStimulus(NB, -1, -1, 1'b0, elapsed);
    checkOutput("full_load_cycles", 64'(elapsed), 64'(NB * (WLP + 3)));

    $display("[TB] reload from done with back-pressure before bit 3");
    applyStimulus(NB, 3, -1, 1'b0, elapsed);
    checkOutput("stall_load_cycles", 64'(elapsed), 64'(NB * (WLP + 3) + 7));

    $display("[TB] reload with random data and a start pulse during bit 10");
    applyStimulus(NB, -1, 10, 1'b1, elapsed);
    checkOutput("ignored_start_cycles", 64'(elapsed), 64'(NB * (WLP + 3)));

    $display("[TB] small instance, 4 bits with 1-cycle pulse");
    run_small(elapsed);
    checkOutput("small_load_cycles", 64'(elapsed), 64'(SNB * (SWP + 3)));

    repeat (3) @(posedge prog_clk);
    #1;
    checkOutput("sb_drained", 64'(sb_q.size()), 64'(0));
    checkOutput("s_sb_drained", 64'(s_q.size()), 64'(0));
    checkOutput("done_sticky", 64'(done), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
